// File: rtl/sharpen_pixel_packer.sv
// sharpen_pixel_packer
//
// Write side of the image-sharpening extension. It accepts sharpened 8-bit
// pixels over a valid/ready handshake, packs four of them little-endian into
// each 32-bit word, and writes the words to DLX data memory. Writes start at a
// programmed word address, and each write is held until the memory
// acknowledges it. A one-cycle DONE pulse reports completion to the DLX
// control unit.
//
// Ports
//   CLK        system clock, rising edge
//   RESET      asynchronous, active-high reset
//   START      one-cycle command, honoured only when idle
//   BASE_ADDR  first memory word address, latched on an accepted START
//   COUNT      number of pixels to write, latched on an accepted START
//   PIX_IN     sharpened pixel
//   PIX_VALID  PIX_IN is valid
//   PIX_READY  packer accepts a pixel this cycle
//   MEM_ADDR   word address of the current write
//   MEM_DATA   packed word (lane 0 = bits 7:0)
//   MEM_BE     byte enables, bit k covers bits 8k+7:8k
//   MEM_WE     write request, held until MEM_ACK
//   MEM_ACK    memory accepted the write this cycle
//   BUSY       transfer in progress (collecting or writing)
//   DONE       one-cycle completion pulse
module sharpen_pixel_packer #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [31:0]      BASE_ADDR,
    input  logic [CNT_W-1:0] COUNT,
    input  logic [PIX_W-1:0] PIX_IN,
    input  logic             PIX_VALID,
    output logic             PIX_READY,
    output logic [31:0]      MEM_ADDR,
    output logic [31:0]      MEM_DATA,
    output logic [3:0]       MEM_BE,
    output logic             MEM_WE,
    input  logic             MEM_ACK,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t           state_q,  state_d;
    logic [31:0]      addr_q,   addr_d;
    logic [31:0]      data_q,   data_d;
    logic [3:0]       be_q,     be_d;
    logic [1:0]       lane_q,   lane_d;
    logic [CNT_W-1:0] remain_q, remain_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            be_q     <= '0;
            lane_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            be_q     <= be_d;
            lane_q   <= lane_d;
            remain_q <= remain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        be_d     = be_q;
        lane_d   = lane_q;
        remain_d = remain_q;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    addr_d   = BASE_ADDR;
                    remain_d = COUNT;
                    data_d   = '0;
                    be_d     = '0;
                    lane_d   = '0;
                    state_d  = (COUNT != '0) ? S_COLLECT : S_FINISH;
                end
            end

            S_COLLECT: begin
                if (PIX_VALID) begin
                    for (int k = 0; k < 4; k++) begin
                        if (lane_q == 2'(k)) begin
                            data_d[k*PIX_W +: PIX_W] = PIX_IN;
                            be_d[k]                  = 1'b1;
                        end
                    end
                    lane_d   = lane_q + 2'd1;
                    remain_d = remain_q - CNT_W'(1);
                    // Flush on a full word or on the final pixel; a short last
                    // word keeps its unfilled lanes at zero with BE cleared.
                    if (lane_q == 2'd3 || remain_q == CNT_W'(1)) begin
                        state_d = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                if (MEM_ACK) begin
                    addr_d  = addr_q + 32'd1;
                    data_d  = '0;
                    be_d    = '0;
                    lane_d  = '0;
                    state_d = (remain_q == '0) ? S_FINISH : S_COLLECT;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Every output is either a register or a pure state decode, so the async
    // reset zeroes them immediately and no input reaches an output directly.
    assign PIX_READY = (state_q == S_COLLECT);
    assign MEM_WE    = (state_q == S_WRITE);
    assign BUSY      = (state_q == S_COLLECT) || (state_q == S_WRITE);
    assign DONE      = (state_q == S_FINISH);
    assign MEM_ADDR  = addr_q;
    assign MEM_DATA  = data_q;
    assign MEM_BE    = be_q;

endmodule

// File: doc/sharpen_pixel_packer.md
# sharpen_pixel_packer

Write-side counterpart of the pixel unpacker in the image-sharpening extension. It accepts sharpened 8-bit pixels one at a time from the sharpening datapath over a valid/ready handshake. It packs four pixels into each 32-bit word and writes the words to DLX data memory starting at a programmed word address, using a hold-until-acknowledge write handshake. It signals completion to the DLX control unit.

## Interface
Parameters:
- PIX_W, 8, pixel width; fixed at 8 (four pixels per 32-bit word).
- CNT_W, 16, width of the pixel-count input.

Ports:
- CLK  in  1  single system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle command; sampled only in IDLE.
- BASE_ADDR  in  32  first memory word address; latched on an accepted START.
- COUNT  in  CNT_W  number of pixels to write; latched on an accepted START.
- PIX_IN  in  8  sharpened pixel.
- PIX_VALID  in  1  PIX_IN is valid.
- PIX_READY  out  1  packer accepts a pixel this cycle.
- MEM_ADDR  out  32  word address of the current write.
- MEM_DATA  out  32  packed word.
- MEM_BE  out  4  byte enables; bit k covers bits 8k+7:8k.
- MEM_WE  out  1  write request.
- MEM_ACK  in  1  memory accepted the write this cycle.
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, COLLECT, WRITE, FINISH.
- IDLE:
  - START=1 latches BASE_ADDR into the address register and COUNT into the remaining-count register.
  - Byte-lane index and data are cleared.
  - Next state is COLLECT if COUNT≠0, else FINISH.
- COLLECT:
  - PIX_READY=1.
  - A pixel transfers when PIX_VALID&PIX_READY at the clock edge.
  - The pixel goes to byte lane = lane index (lane 0 = bits 7:0, little-endian), and that lane's BE bit is set.
  - On each transfer, lane index increments and remaining count decrements.
  - Go to WRITE when the accepted pixel fills lane 3 or is the last pixel (remaining becomes 0).
- WRITE:
  - MEM_WE=1. MEM_ADDR, MEM_DATA and MEM_BE stay stable until MEM_ACK=1 is sampled.
  - PIX_READY=0.
  - On ACK:
    - Address increments by 1 (modulo 2^32, wraps 0xFFFFFFFF→0).
    - Data, BE and lane index clear.
    - Next state is FINISH if remaining=0, else COLLECT.
- FINISH: DONE=1 for exactly one cycle, then IDLE.
- Partial last word: unfilled lanes carry data 0x00 with BE=0.
- MEM_ACK is ignored when MEM_WE=0.
- START outside IDLE is ignored; latched parameters are unaffected.
- BUSY=1 in COLLECT and WRITE; BUSY=0 in IDLE and FINISH.
- PIX_IN is ignored when PIX_READY=0. PIX_VALID may drop at any time and gaps only stall COLLECT.
- Output reset values:
  - PIX_READY=0, MEM_WE=0, MEM_ADDR=0, MEM_DATA=0, MEM_BE=0, BUSY=0, DONE=0.
  - State is IDLE and all internal registers are cleared.
- RESET asserted mid-operation:
  - MEM_WE and all other outputs go to reset values immediately, without waiting for a clock.
  - The in-flight word is discarded and DONE is not generated.
  - No write is pending after RESET deasserts.
- COUNT=0: no memory write; DONE pulses in the second cycle after START.

## Timing
- START accepted at edge t: BUSY=1 and PIX_READY=1 from cycle t+1.
- Four pixels accepted on consecutive edges t+1..t+4: MEM_WE=1 from cycle t+5.
- MEM_ACK sampled high at edge w: MEM_WE=0 from cycle w+1.
  - Cycle w+1 is COLLECT (PIX_READY=1) if pixels remain, otherwise FINISH (DONE=1).
- Peak throughput: one word per 5 cycles, with no bubble after ACK.
- Latency from the last pixel accepted to DONE with immediate ACK: 2 cycles (WRITE, then FINISH).
- All outputs are registered or decoded from state only. There is no combinational path from PIX_VALID or MEM_ACK to any output.

## Test plan
- BASE_ADDR=0x100, COUNT=4, pixels 0x11,0x22,0x33,0x44 back-to-back, ACK immediate:
  - One write: ADDR=0x100, DATA=0x44332211, BE=0xF.
  - DONE pulses once; BUSY low afterwards.
- COUNT=6, pixels 0x01..0x06:
  - Writes 0x100/0x04030201/BE=0xF, then 0x101/0x00000605/BE=0x3.
- COUNT=0: START gives no MEM_WE, and DONE=1 exactly one pulse, two cycles after START.
- COUNT=4 with ACK delayed 3 cycles and PIX_VALID toggling 1,0,1:
  - WE, ADDR, DATA and BE hold stable for 4 cycles.
  - PIX_READY=0 throughout WRITE.
  - Data matches the accepted pixels only.
- BASE_ADDR=0xFFFFFFFF, COUNT=8: second write goes to address 0x00000000.
- Interference and reset:
  - START pulsed during COLLECT with a different BASE_ADDR: ignored, and the original sequence completes.
  - RESET asserted during WRITE: MEM_WE drops before the next edge, there is no DONE, and outputs read all zero.
